// File: rtl/sr_ff_driver_pkg.sv
// Shared types and constants for the SR flip-flop command driver.
// States, error codes and the counter-width helper used by sr_ff_driver.
package sr_ff_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;

    // Wide enough to hold the larger of the two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned pw, input int unsigned to);
        int unsigned m;
        m = (pw > to) ? pw : to;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Command handshake and flip-flop drive/feedback bundle for sr_ff_driver.
// master = the driver side, slave = the controller plus storage-cell side.
interface sr_ff_driver_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_val;
    logic       s;
    logic       r;
    logic       q_fb;
    logic       qbar_fb;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        input  req_valid, req_val, q_fb, qbar_fb,
        output req_ready, s, r, busy, done, err, err_code
    );

    modport slave (
        output req_valid, req_val, q_fb, qbar_fb,
        input  req_ready, s, r, busy, done, err, err_code
    );

endinterface

// File: rtl/sr_ff_driver_pulse_timer.sv
// sr_pulse_timer: loadable, saturating up-counter with a terminal flag.
// Shared by the pulse-width phase and the feedback-timeout phase.
module sr_pulse_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_term = (r_cnt >= i_limit);

endmodule

// File: rtl/sr_ff_driver.sv
// Command-side master for an SR flip-flop: pulses s or r, then checks q/qbar feedback.
// Optional macro SR_FF_DRIVER_SKIP_EN: finish immediately when feedback already matches.
module sr_ff_driver
    import sr_ff_driver_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned TIMEOUT = 8
) (
    input logic             clk,
    input logic             rst,
    sr_ff_driver_if.master  bus
);

    localparam int unsigned      CNT_W       = cnt_width(PULSE_W, TIMEOUT);
    localparam logic [CNT_W-1:0] PULSE_LIM   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_tgt;
    logic       r_s;
    logic       r_r;
    logic       r_done;
    logic       r_err;
    logic [1:0] r_err_code;

    logic             w_accept;
    logic             w_skip;
    logic             w_fb_illegal;
    logic             w_fb_match;
    logic             w_term;
    logic             w_load;
    logic             w_inc;
    logic [CNT_W-1:0] w_limit;

    always_comb begin
        w_accept     = (r_state == IDLE) && bus.req_valid;
        w_fb_illegal = (bus.q_fb == bus.qbar_fb);
        w_fb_match   = (bus.q_fb == r_tgt);
`ifdef SR_FF_DRIVER_SKIP_EN
        w_skip       = (bus.q_fb == bus.req_val) && (bus.qbar_fb != bus.req_val);
`else
        w_skip       = 1'b0;
`endif
        w_limit      = (r_state == DRIVE) ? PULSE_LIM : TIMEOUT_LIM;
        // One counter serves both phases: cleared on accept and again on entry to WAIT.
        w_load       = (w_accept && !w_skip) || ((r_state == DRIVE) && w_term);
        w_inc        = ((r_state == DRIVE) && !w_term) ||
                       ((r_state == WAIT) && !w_fb_illegal && !w_fb_match && !w_term);
    end

    sr_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val ('0),
        .i_inc      (w_inc),
        .i_limit    (w_limit),
        .o_term     (w_term)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_tgt      <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tgt <= bus.req_val;
                        if (w_skip) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= DRIVE;
                            r_s     <= bus.req_val;
                            r_r     <= ~bus.req_val;
                        end
                    end
                end
                DRIVE: begin
                    if (w_term) begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Illegal feedback outranks a match, which outranks the timeout.
                    if (w_fb_illegal) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_ILLEGAL;
                        r_state    <= IDLE;
                    end else if (w_fb_match) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_term) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.s         = r_s;
    assign bus.r         = r_r;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.err_code  = r_err_code;

    a_sr_exclusive: assert property (@(posedge clk) !(r_s && r_r));
    a_sr_only_in_drive: assert property (@(posedge clk) (r_state != DRIVE) |-> !(r_s || r_r));
    a_done_err_exclusive: assert property (@(posedge clk) !(r_done && r_err));

endmodule

// File: tb/tb_sr_ff_driver.sv
// Self-checking bench for sr_ff_driver: transaction-age model plus directed commands.
// Honours SR_FF_DRIVER_SKIP_EN when the same macro is defined for the RTL.
module tb_sr_ff_driver;
    import sr_ff_driver_pkg::*;

    localparam int unsigned PW = 2;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sr_ff_driver_if bus ();

    sr_ff_driver #(
        .PULSE_W (PW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Storage cell: behavioural SR flip-flop, or forced feedback patterns.
    logic ff_q    = 1'b0;
    logic fb_mode = 1'b0;
    logic f_q     = 1'b0;
    logic f_qb    = 1'b1;

    always @(posedge clk) begin
        if (bus.s && !bus.r)      ff_q <= 1'b1;
        else if (bus.r && !bus.s) ff_q <= 1'b0;
    end

    assign bus.q_fb    = fb_mode ? f_q  : ff_q;
    assign bus.qbar_fb = fb_mode ? f_qb : ~ff_q;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a command is tracked by its age in edges since accept.
    bit         m_known  = 1'b0;
    bit         m_active = 1'b0;
    int         m_age    = 0;
    logic       m_tgt    = 1'b0;
    logic       e_s = 0, e_r = 0, e_done = 0, e_err = 0, e_busy = 0;
    logic [1:0] e_code = 2'd0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_known  = 1'b1;
                m_active = 1'b0;
                e_done   = 1'b0;
                e_err    = 1'b0;
                e_code   = ERR_NONE;
            end else begin
                e_done = 1'b0;
                e_err  = 1'b0;
                if (!m_active) begin
                    if (bus.req_valid) begin
                        m_tgt = bus.req_val;
`ifdef SR_FF_DRIVER_SKIP_EN
                        if (bus.q_fb == bus.req_val && bus.qbar_fb == !bus.req_val) e_done = 1'b1;
                        else begin m_active = 1'b1; m_age = 0; end
`else
                        m_active = 1'b1;
                        m_age    = 0;
`endif
                    end
                end else begin
                    m_age++;
                    if (m_age > int'(PW)) begin
                        if (bus.q_fb == bus.qbar_fb) begin
                            e_err = 1'b1; e_code = ERR_ILLEGAL; m_active = 1'b0;
                        end else if (bus.q_fb == m_tgt) begin
                            e_done = 1'b1; m_active = 1'b0;
                        end else if (m_age - int'(PW) == int'(TO)) begin
                            e_err = 1'b1; e_code = ERR_TIMEOUT; m_active = 1'b0;
                        end
                    end
                end
            end
            e_busy = m_active;
            e_s    = m_active && (m_age < int'(PW)) && m_tgt;
            e_r    = m_active && (m_age < int'(PW)) && !m_tgt;
            @(negedge clk);
            if (m_known) begin
                chk("mon_s",     32'(bus.s),         32'(e_s));
                chk("mon_r",     32'(bus.r),         32'(e_r));
                chk("mon_busy",  32'(bus.busy),      32'(e_busy));
                chk("mon_ready", 32'(bus.req_ready), 32'(!e_busy));
                chk("mon_done",  32'(bus.done),      32'(e_done));
                chk("mon_err",   32'(bus.err),       32'(e_err));
                chk("mon_code",  32'(bus.err_code),  32'(e_code));
                chk("mon_s_and_r", 32'(bus.s & bus.r), 32'd0);
            end
        end
    end

    // Issue one command at the current negedge; returns at the negedge where done/err shows.
    task automatic run_cmd(input string tag, input logic val, input int exp_s, input int exp_r,
                           input int exp_lat, input logic exp_done, input logic [1:0] exp_code,
                           input bit poke);
        int         ns = 0;
        int         nr = 0;
        int         lat = 0;
        logic       got_done = 1'b0;
        logic       got_err  = 1'b0;
        logic [1:0] code = 2'd0;
        bus.req_valid = 1'b1;
        bus.req_val   = val;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_val   = ~val;
            end
            if (poke && k == 2) bus.req_valid = 1'b1;
            if (poke && k == 3) bus.req_valid = 1'b0;
            ns += int'(bus.s);
            nr += int'(bus.r);
            if (bus.done || bus.err) begin
                lat      = k;
                got_done = bus.done;
                got_err  = bus.err;
                code     = bus.err_code;
            end
        end
        bus.req_valid = 1'b0;
        chk({tag, "_s_cycles"}, 32'(ns), 32'(exp_s));
        chk({tag, "_r_cycles"}, 32'(nr), 32'(exp_r));
        chk({tag, "_latency"},  32'(lat), 32'(exp_lat));
        chk({tag, "_done"},     32'(got_done), 32'(exp_done));
        chk({tag, "_err"},      32'(got_err),  32'(!exp_done));
        if (!exp_done) chk({tag, "_code"}, 32'(code), 32'(exp_code));
    endtask

    initial begin
        int seen;
        bus.req_valid = 1'b0;
        bus.req_val   = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst_s",     32'(bus.s),         32'd0);
        chk("rst_r",     32'(bus.r),         32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_err",   32'(bus.err),       32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_code",  32'(bus.err_code),  32'd0);
        @(negedge clk);

        run_cmd("set", 1'b1, 2, 0, 4, 1'b1, ERR_NONE, 1'b0);
        @(negedge clk);

        run_cmd("clr", 1'b0, 0, 2, 4, 1'b1, ERR_NONE, 1'b1);
        chk("b2b_ready_in_done", 32'(bus.req_ready), 32'd1);
        run_cmd("b2b", 1'b1, 2, 0, 4, 1'b1, ERR_NONE, 1'b0);
        @(negedge clk);

        fb_mode = 1'b1; f_q = 1'b0; f_qb = 1'b1;
        run_cmd("tmo", 1'b1, 2, 0, int'(PW + TO + 1), 1'b0, ERR_TIMEOUT, 1'b0);
        @(negedge clk);
        chk("tmo_code_held", 32'(bus.err_code), 32'(ERR_TIMEOUT));

        f_q = 1'b1; f_qb = 1'b1;
        run_cmd("ill", 1'b0, 0, 2, 4, 1'b0, ERR_ILLEGAL, 1'b0);
        @(negedge clk);

        fb_mode = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_val   = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid_s_before_rst", 32'(bus.s), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_s_after_rst",    32'(bus.s),        32'd0);
        chk("mid_busy_after_rst", 32'(bus.busy),     32'd0);
        chk("mid_code_after_rst", 32'(bus.err_code), 32'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(bus.done) + int'(bus.err);
        end
        chk("mid_no_done_err", 32'(seen), 32'd0);

        fb_mode = 1'b1; f_q = 1'b1; f_qb = 1'b0;
`ifdef SR_FF_DRIVER_SKIP_EN
        run_cmd("skip", 1'b1, 0, 0, 1, 1'b1, ERR_NONE, 1'b0);
`else
        run_cmd("skip", 1'b1, 2, 0, 4, 1'b1, ERR_NONE, 1'b0);
`endif
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
